// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the raster timing generator:
// 640x480@60 default timing, sync polarity encoding, colour-bar palette
// and the line/frame total functions.
package video_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Asserted level of h_sync/v_sync.
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;
    localparam bit DEF_SYNC_POL     = SYNC_ACTIVE_LOW;

    localparam int unsigned NUM_BARS = 8;

    // Bar colours, left to right across the active line.
    localparam logic [0:7][23:0] BAR_COLOUR = {
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic int unsigned calc_h_total(input int unsigned active,
                                                 input int unsigned fp,
                                                 input int unsigned sync,
                                                 input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned calc_v_total(input int unsigned active,
                                                 input int unsigned fp,
                                                 input int unsigned sync,
                                                 input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing/pixel bundle between the raster generator and its consumer.
// tpg_sel exists only when VTG_TPG_EN is defined.
interface video_timing_gen_if;

    logic        ce;
    logic [23:0] pixel_in;
    logic        h_sync;
    logic        v_sync;
    logic        de;
    logic [15:0] x;
    logic [15:0] y;
    logic        frame_start;
    logic        line_start;
    logic [23:0] pixel_out;
`ifdef VTG_TPG_EN
    logic        tpg_sel;

    modport master (
        input  ce, pixel_in, tpg_sel,
        output h_sync, v_sync, de, x, y, frame_start, line_start, pixel_out
    );

    modport slave (
        output ce, pixel_in, tpg_sel,
        input  h_sync, v_sync, de, x, y, frame_start, line_start, pixel_out
    );
`else
    modport master (
        input  ce, pixel_in,
        output h_sync, v_sync, de, x, y, frame_start, line_start, pixel_out
    );

    modport slave (
        output ce, pixel_in,
        input  h_sync, v_sync, de, x, y, frame_start, line_start, pixel_out
    );
`endif

endinterface

// File: rtl/video_timing_gen_colour_bar.sv
// colour_bar_gen: eight equal vertical bars across the active line.
// Compiled only when VTG_TPG_EN is defined. The bar index comes from a
// width counter restarted by line_start, so no divider is needed.
// colour is combinational and belongs to the current counter position.
`ifdef VTG_TPG_EN
module colour_bar_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        de,
    input  logic        line_start,
    output logic [23:0] colour
);

    localparam int unsigned BAR_W    = H_ACTIVE / NUM_BARS;
    localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

    logic [15:0] cnt_q;
    logic [2:0]  bar_q;
    logic [15:0] cnt_cur;
    logic [2:0]  bar_cur;

    // line_start forces the first pixel of a line into bar 0 immediately.
    always_comb begin
        cnt_cur = line_start ? '0 : cnt_q;
        bar_cur = line_start ? '0 : bar_q;
    end

    // Advance the width counter on each active pixel, step bar at width end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            bar_q <= '0;
        end else if (ce) begin
            if (de) begin
                if (cnt_cur == BAR_LAST) begin
                    cnt_q <= '0;
                    bar_q <= bar_cur + 3'd1;
                end else begin
                    cnt_q <= cnt_cur + 16'd1;
                    bar_q <= bar_cur;
                end
            end else if (line_start) begin
                cnt_q <= '0;
                bar_q <= '0;
            end
        end
    end

    assign colour = BAR_COLOUR[bar_cur];

endmodule
`endif

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source. Horizontal/vertical counters,
// sync pulses, active-video flag, coordinates and a registered pixel,
// all advancing on ce and delayed by one ce cycle from the counters.
// Optional test pattern: define VTG_TPG_EN to add tpg_sel and colour bars.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = DEF_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst_n,
    video_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 65535 || V_TOTAL > 65535 || H_ACTIVE == 0 ||
        (H_ACTIVE % NUM_BARS) != 0) begin : g_bad_cfg
        $error("video_timing_gen: illegal timing parameters");
    end

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] hc;
    logic [15:0] vc;
    logic [15:0] hc_nxt;
    logic [15:0] vc_nxt;
    logic        h_last;
    logic        v_last;
    logic        h_sync_c;
    logic        v_sync_c;
    logic        de_c;
    logic        fs_c;
    logic        ls_c;
    logic [23:0] pix_src;

    logic        h_sync_q;
    logic        v_sync_q;
    logic        de_q;
    logic [15:0] x_q;
    logic [15:0] y_q;
    logic        fs_q;
    logic        ls_q;
    logic [23:0] pix_q;

    // Counter wrap and decode of the current position.
    always_comb begin
        h_last   = (hc == H_LAST);
        v_last   = (vc == V_LAST);
        hc_nxt   = h_last ? '0 : hc + 16'd1;
        vc_nxt   = vc;
        if (h_last) begin
            vc_nxt = v_last ? '0 : vc + 16'd1;
        end
        h_sync_c = ((hc >= HS_BEG) && (hc < HS_END)) ? SYNC_POL : ~SYNC_POL;
        v_sync_c = ((vc >= VS_BEG) && (vc < VS_END)) ? SYNC_POL : ~SYNC_POL;
        de_c     = (hc < H_ACT) && (vc < V_ACT);
        fs_c     = (hc == 16'd0) && (vc == 16'd0);
        ls_c     = (hc == 16'd0);
    end

`ifdef VTG_TPG_EN
    logic [23:0] bar_colour;
    logic        tpg_q;
    logic        tpg_eff;

    colour_bar_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_colour_bar_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (bus.ce),
        .de         (de_c),
        .line_start (ls_c),
        .colour     (bar_colour)
    );

    // Latch the pattern select once per frame so a frame is never mixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpg_q <= 1'b0;
        end else if (bus.ce && fs_c) begin
            tpg_q <= bus.tpg_sel;
        end
    end

    // The first pixel of a frame already uses the freshly sampled select.
    assign tpg_eff = fs_c ? bus.tpg_sel : tpg_q;
    assign pix_src = tpg_eff ? bar_colour : bus.pixel_in;
`else
    assign pix_src = bus.pixel_in;
`endif

    // Raster counters, advancing only on ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (bus.ce) begin
            hc <= hc_nxt;
            vc <= vc_nxt;
        end
    end

    // Register the decoded position and its pixel; everything holds when ce=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_sync_q <= ~SYNC_POL;
            v_sync_q <= ~SYNC_POL;
            de_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            fs_q     <= 1'b0;
            ls_q     <= 1'b0;
            pix_q    <= '0;
        end else if (bus.ce) begin
            h_sync_q <= h_sync_c;
            v_sync_q <= v_sync_c;
            de_q     <= de_c;
            x_q      <= hc;
            y_q      <= vc;
            fs_q     <= fs_c;
            ls_q     <= ls_c;
            pix_q    <= de_c ? pix_src : 24'h0;
        end
    end

    assign bus.h_sync      = h_sync_q;
    assign bus.v_sync      = v_sync_q;
    assign bus.de          = de_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.frame_start = fs_q;
    assign bus.line_start  = ls_q;
    assign bus.pixel_out   = pix_q;

endmodule
